// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation: hall sync/filter, sector decode, high-side PWM,
// per-leg dead time and sticky fault on illegal hall codes.
module commutation_sequencer #(
    parameter int PWM_BITS  = 8,
    parameter int DEAD      = 8,
    parameter int HALL_FILT = 4
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic                dir,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                hall1,
    input  logic                hall2,
    input  logic                hall3,
    output logic [5:0]          PHASES,
    output logic [2:0]          sector,
    output logic                fault,
    output logic [15:0]         comm_count
);

    localparam int DW = $clog2(DEAD + 1);
    localparam int FW = $clog2(HALL_FILT + 1);
    localparam logic [DW-1:0]       DEAD_C  = DW'(DEAD);
    localparam logic [FW-1:0]       FILT_C  = FW'(HALL_FILT);
    localparam logic [PWM_BITS-1:0] PWM_TOP = PWM_BITS'((2 ** PWM_BITS) - 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [2:0]          r_hall_s1, r_hall_s2, r_hall_cand, r_hall_acc;
    logic                r_acc_vld;
    logic [FW-1:0]       r_filt_cnt, w_filt_cnt_nxt;
    logic [2:0]          r_sector, w_code_sec, w_sec;
    logic                w_code_legal, w_illegal, w_sec_change;
    logic [15:0]         r_comm;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_pwm_on;
    logic [DW-1:0]       r_dead [3];
    logic [1:0]          w_fwd_hi, w_fwd_lo, w_hi_leg, w_lo_leg;
    logic [5:0]          w_req, w_ph_nxt, r_phases;

    // Count of consecutive cycles the synced code has matched the candidate.
    always_comb begin
        if (r_hall_s2 != r_hall_cand)
            w_filt_cnt_nxt = FW'(1);
        else if (r_filt_cnt == FILT_C)
            w_filt_cnt_nxt = r_filt_cnt;
        else
            w_filt_cnt_nxt = r_filt_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_hall_s1   <= '0;
            r_hall_s2   <= '0;
            r_hall_cand <= '0;
            r_hall_acc  <= '0;
            r_filt_cnt  <= '0;
            r_acc_vld   <= 1'b0;
        end else begin
            r_hall_s1   <= {hall3, hall2, hall1};
            r_hall_s2   <= r_hall_s1;
            r_hall_cand <= r_hall_s2;
            r_filt_cnt  <= w_filt_cnt_nxt;
            if (w_filt_cnt_nxt == FILT_C) begin
                r_hall_acc <= r_hall_s2;
                r_acc_vld  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_code_legal = 1'b1;
        w_code_sec   = 3'd0;
        case (r_hall_acc)
            3'b001:  w_code_sec = 3'd0;
            3'b011:  w_code_sec = 3'd1;
            3'b010:  w_code_sec = 3'd2;
            3'b110:  w_code_sec = 3'd3;
            3'b100:  w_code_sec = 3'd4;
            3'b101:  w_code_sec = 3'd5;
            default: w_code_legal = 1'b0;
        endcase
        w_sec     = (r_acc_vld && w_code_legal) ? w_code_sec : r_sector;
        w_illegal = r_acc_vld && !w_code_legal;
    end

    // No accepted code yet after reset: IDLE simply waits for one.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable && r_acc_vld) w_state_nxt = w_code_legal ? ST_RUN : ST_FAULT;
            ST_RUN:   if (!enable) w_state_nxt = ST_IDLE;
                      else if (w_illegal) w_state_nxt = ST_FAULT;
            ST_FAULT: if (!enable) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        w_sec_change = (r_state == ST_RUN) && (w_state_nxt == ST_RUN) && (w_sec != r_sector);
    end

    assign w_pwm_on = (r_pwm_cnt < duty);

    always_comb begin
        w_fwd_hi = 2'd0;
        w_fwd_lo = 2'd1;
        case (w_sec)
            3'd0:    begin w_fwd_hi = 2'd0; w_fwd_lo = 2'd1; end
            3'd1:    begin w_fwd_hi = 2'd0; w_fwd_lo = 2'd2; end
            3'd2:    begin w_fwd_hi = 2'd1; w_fwd_lo = 2'd2; end
            3'd3:    begin w_fwd_hi = 2'd1; w_fwd_lo = 2'd0; end
            3'd4:    begin w_fwd_hi = 2'd2; w_fwd_lo = 2'd0; end
            3'd5:    begin w_fwd_hi = 2'd2; w_fwd_lo = 2'd1; end
            default: begin w_fwd_hi = 2'd0; w_fwd_lo = 2'd1; end
        endcase
        w_hi_leg = dir ? w_fwd_lo : w_fwd_hi;
        w_lo_leg = dir ? w_fwd_hi : w_fwd_lo;
    end

    // A gate already on may stay on; a new turn-on needs the opposite gate
    // off and the leg's dead counter saturated.
    always_comb begin
        w_req    = '0;
        w_ph_nxt = '0;
        if (w_state_nxt == ST_RUN) begin
            for (int unsigned l = 0; l < 3; l++) begin
                w_req[l]     = (w_hi_leg == 2'(l)) && w_pwm_on;
                w_req[l + 3] = (w_lo_leg == 2'(l));
            end
        end
        for (int unsigned l = 0; l < 3; l++) begin
            w_ph_nxt[l]     = w_req[l] &&
                              (r_phases[l] || (!r_phases[l + 3] && r_dead[l] == DEAD_C));
            w_ph_nxt[l + 3] = w_req[l + 3] &&
                              (r_phases[l + 3] || (!r_phases[l] && r_dead[l] == DEAD_C));
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_sector  <= '0;
            r_comm    <= '0;
            r_pwm_cnt <= '0;
            r_phases  <= '0;
            // Counters start at zero so every leg serves a full dead time after reset.
            for (int unsigned l = 0; l < 3; l++)
                r_dead[l] <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_phases <= w_ph_nxt;
            if (r_acc_vld && w_code_legal)
                r_sector <= w_code_sec;
            if (w_sec_change)
                r_comm <= r_comm + 16'd1;
            r_pwm_cnt <= (r_pwm_cnt == PWM_TOP) ? '0 : r_pwm_cnt + 1'b1;
            for (int unsigned l = 0; l < 3; l++) begin
                if (r_phases[l] || r_phases[l + 3])
                    r_dead[l] <= '0;
                else if (r_dead[l] != DEAD_C)
                    r_dead[l] <= r_dead[l] + 1'b1;
            end
        end
    end

    assign PHASES     = r_phases;
    assign sector     = r_sector;
    assign fault      = (r_state == ST_FAULT);
    assign comm_count = r_comm;

endmodule
